// File: rtl/nes_tetris_mem_arbiter.sv
// rtl/nes_tetris_mem_arbiter.sv - two-master arbiter for the shared 4x32 on-chip memory
module nes_tetris_mem_arbiter #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 32,
  parameter int BE_W     = DATA_W / 8,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  // requester 0: Nios II data master
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // requester 1: game engine
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // memory s1 port
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              proto_err
);

  // last_grant: 0 = m0 won the last access, 1 = m1 won it
  logic              last_grant;
  logic              req0;
  logic              req1;
  logic              active;
  logic              grant0;
  logic              grant1;
  logic              any_grant;
  logic              rd_accept;
  logic              rw_both;

  // previous memory-side values, held while nothing is granted
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  // return pipeline: stage 1 = read issued, memory q arrives next edge
  logic              p1_valid;
  logic              p1_id;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign active    = reset_n & ~freeze;
  assign any_grant = grant0 | grant1;
  assign mem_clken = reset_n;

  // Pick the winner for this cycle; ties go by rotation or fixed priority
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (active) begin
      if (req0 && !req1) begin
        grant0 = 1'b1;
      end else if (req1 && !req0) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        if (ARB_MODE == 1) begin
          grant0 = 1'b1;
        end else if (last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  // Route the winner onto the memory port; a read+write request acts as a write
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = addr_q;
    mem_byteenable = be_q;
    mem_writedata  = wdata_q;
    rd_accept      = 1'b0;
    rw_both        = 1'b0;
    if (grant0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_writedata  = m0_writedata;
      mem_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
      rd_accept      = m0_read & ~m0_write;
      rw_both        = m0_read & m0_write;
    end else if (grant1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_writedata  = m1_writedata;
      mem_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
      rd_accept      = m1_read & ~m1_write;
      rw_both        = m1_read & m1_write;
    end
  end

  // Remember who won and what was driven, so idle cycles hold the port steady
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else if (any_grant) begin
      last_grant <= grant1;
      addr_q     <= mem_address;
      be_q       <= mem_byteenable;
      wdata_q    <= mem_writedata;
    end
  end

  // Sticky protocol error when a winner asserted read and write together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (rw_both) begin
      proto_err <= 1'b1;
    end
  end

  // Stage 1 of the return path: tag each accepted read with its requester
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_valid <= 1'b0;
      p1_id    <= 1'b0;
    end else begin
      p1_valid <= rd_accept;
      p1_id    <= grant1;
    end
  end

  // Stage 2: capture memory q for the tagged requester and strobe it for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= p1_valid & ~p1_id;
      m1_readdatavalid <= p1_valid &  p1_id;
      if (p1_valid && !p1_id) begin
        m0_readdata <= mem_readdata;
      end
      if (p1_valid && p1_id) begin
        m1_readdata <= mem_readdata;
      end
    end
  end

endmodule
